// File: rtl/sa_pkg.sv
// sa_pkg: shared systolic-array sizes and the result unloader state type
package sa_pkg;
  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int ELEM_W = 32;
  localparam int BPE = ELEM_W / 8;
  localparam int TOTAL_BYTES = ROWS * COLS * BPE;
  typedef enum logic [1:0] {IDLE, SEND, CKSUM, DONE} unl_state_t;
endpackage

// File: rtl/elem_serializer.sv
// elem_serializer: picks one byte (MSB first) of one snapshot element
module elem_serializer #(
  parameter int NE = sa_pkg::ROWS * sa_pkg::COLS,
  parameter int ELEM_W = sa_pkg::ELEM_W,
  parameter int EW = 4,
  parameter int BW = 2
) (
  input  logic [ELEM_W-1:0] snap [0:NE-1],
  input  logic [EW-1:0]     elem_idx,
  input  logic [BW-1:0]     byte_idx,
  output logic [7:0]        byte_out
);
  logic [ELEM_W-1:0] shifted;
  // shifting left by whole bytes brings the wanted byte to the top
  assign shifted = snap[elem_idx] << {byte_idx, 3'b000};
  assign byte_out = shifted[ELEM_W-1 -: 8];
endmodule

// File: rtl/result_unloader.sv
// result_unloader: streams a snapshot of the result matrix out as bytes; UNLOADER_CHECKSUM_EN appends an XOR checksum byte
module result_unloader
  import sa_pkg::unl_state_t, sa_pkg::IDLE, sa_pkg::SEND, sa_pkg::CKSUM, sa_pkg::DONE;
#(
  parameter int ROWS = sa_pkg::ROWS,
  parameter int COLS = sa_pkg::COLS,
  parameter int ELEM_W = sa_pkg::ELEM_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ELEM_W-1:0] mem_c [0:ROWS*COLS-1],
  input  logic              unload_start,
  output logic [7:0]        data_out,
  output logic              data_out_valid,
  input  logic              data_out_ready,
  output logic              busy,
  output logic              unload_done
);
  localparam int BPE = ELEM_W / 8;
  localparam int NE = ROWS * COLS;
  localparam int BW = BPE > 1 ? $clog2(BPE) : 1;
  localparam int EW = NE > 1 ? $clog2(NE) : 1;
  unl_state_t state;
  logic [ELEM_W-1:0] snap [0:NE-1];
  logic [EW-1:0] elem_idx, ne;
  logic [BW-1:0] byte_idx, nb;
  logic [7:0] nxt_byte;
  logic xfer, last_byte, last;
`ifdef UNLOADER_CHECKSUM_EN
  logic [7:0] cksum;
`endif
  assign xfer = data_out_valid && data_out_ready;
  assign last_byte = byte_idx == BW'(BPE - 1);
  assign last = last_byte && elem_idx == EW'(NE - 1);
  assign nb = last_byte ? '0 : byte_idx + 1'b1;
  assign ne = last ? '0 : last_byte ? elem_idx + 1'b1 : elem_idx;
  // data_out is registered, so the serializer looks up the byte after the current one
  elem_serializer #(.NE(NE), .ELEM_W(ELEM_W), .EW(EW), .BW(BW)) u_ser (
    .snap(snap),
    .elem_idx(ne),
    .byte_idx(nb),
    .byte_out(nxt_byte)
  );
  // snapshot captured only when a start is accepted, so later mem_c changes are invisible
  always_ff @(posedge clk)
    if (!rst && state == IDLE && unload_start) snap <= mem_c;
  // control FSM with registered byte, valid, busy and done
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      data_out <= '0;
      data_out_valid <= 1'b0;
      busy <= 1'b0;
      unload_done <= 1'b0;
      elem_idx <= '0;
      byte_idx <= '0;
`ifdef UNLOADER_CHECKSUM_EN
      cksum <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (unload_start) begin
          elem_idx <= '0;
          byte_idx <= '0;
          data_out <= mem_c[0][ELEM_W-1 -: 8];
          data_out_valid <= 1'b1;
          busy <= 1'b1;
          state <= SEND;
`ifdef UNLOADER_CHECKSUM_EN
          cksum <= '0;
`endif
        end
        SEND: if (xfer) begin
          byte_idx <= nb;
          elem_idx <= ne;
`ifdef UNLOADER_CHECKSUM_EN
          cksum <= cksum ^ data_out;
          data_out <= last ? cksum ^ data_out : nxt_byte;
          if (last) state <= CKSUM;
`else
          data_out <= last ? 8'h00 : nxt_byte;
          if (last) begin
            data_out_valid <= 1'b0;
            unload_done <= 1'b1;
            state <= DONE;
          end
`endif
        end
`ifdef UNLOADER_CHECKSUM_EN
        CKSUM: if (xfer) begin
          data_out <= '0;
          data_out_valid <= 1'b0;
          unload_done <= 1'b1;
          state <= DONE;
        end
`endif
        DONE: begin
          unload_done <= 1'b0;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_result_unloader.sv
// tb_result_unloader: random and directed streams checked against a byte-list reference model
module tb_result_unloader;
`ifdef UNLOADER_CHECKSUM_EN
  localparam int NBYTES = 65;
`else
  localparam int NBYTES = 64;
`endif
  logic clk = 1'b0;
  logic rst, unload_start, data_out_ready;
  logic [31:0] mem_c [0:15];
  logic [7:0] data_out, last_rx;
  logic data_out_valid, busy, unload_done;
  int n_assert, n_fail;
  logic [7:0] exp_q[$];

  result_unloader dut (
    .clk(clk),
    .rst(rst),
    .mem_c(mem_c),
    .unload_start(unload_start),
    .data_out(data_out),
    .data_out_valid(data_out_valid),
    .data_out_ready(data_out_ready),
    .busy(busy),
    .unload_done(unload_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // expected stream: every element row-major, MSB first, then optional XOR of all bytes
  task automatic build_exp();
    logic [7:0] x;
    exp_q = {};
    x = 8'h00;
    for (int i = 0; i < 16; i++)
      for (int b = 0; b < 4; b++) begin
        exp_q.push_back(8'(mem_c[i] >> (8 * (3 - b))));
        x ^= 8'(mem_c[i] >> (8 * (3 - b)));
      end
`ifdef UNLOADER_CHECKSUM_EN
    exp_q.push_back(x);
`endif
  endtask

  task automatic randomize_mem();
    for (int i = 0; i < 16; i++) mem_c[i] = $urandom;
  endtask

  // mode: 0 ready always, 1 ready toggles 1010, 2 random ready
  task automatic run(input int mode, input int start_at, input int rst_at, input bit scramble, input int exp_done);
    int got, dones;
    bit stall, quit;
    logic [7:0] held;
    got = 0; dones = 0; stall = 0; quit = 0; held = 8'h00;
    build_exp();
    unload_start = 1'b1;
    @(negedge clk);
    for (int c = 1; c < 1000 && dones == 0 && !quit; c++) begin
      unload_start = got == start_at;
      if (scramble && c == 1) for (int i = 0; i < 16; i++) mem_c[i] = 32'hFFFF_FFFF;
      if (got == rst_at) begin
        rst = 1'b1;
        unload_start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_valid", data_out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", unload_done, 0);
        @(negedge clk);
        chk("rst_no_done", unload_done, 0);
        chk("rst_idle_valid", data_out_valid, 0);
        quit = 1;
      end else if (unload_done) begin
        dones++;
        chk("byte_count", got, NBYTES);
        if (exp_done > 0) chk("done_cycle", c, exp_done);
        chk("done_valid", data_out_valid, 0);
        chk("done_busy", busy, 1);
        @(negedge clk);
      end else begin
        chk("busy", busy, 1);
        chk("valid", data_out_valid, 1);
        if (stall) chk("hold", data_out, held);
        data_out_ready = mode == 0 ? 1'b1 : mode == 1 ? c[0] : 1'($urandom_range(0, 1));
        if (data_out_ready) begin
          if (got >= NBYTES) chk("extra_byte", got, NBYTES - 1);
          else chk($sformatf("byte%0d", got), data_out, exp_q[got]);
          last_rx = data_out;
          got++;
          stall = 0;
        end else begin
          stall = 1;
          held = data_out;
        end
        @(negedge clk);
      end
    end
    unload_start = 1'b0;
    if (!quit) begin
      chk("done_seen", dones, 1);
      chk("post_done", unload_done, 0);
      chk("post_busy", busy, 0);
    end
  endtask

  initial begin
    n_assert = 0;
    n_fail = 0;
    rst = 1'b1;
    unload_start = 1'b0;
    data_out_ready = 1'b0;
    last_rx = 8'h00;
    for (int i = 0; i < 16; i++) mem_c[i] = 32'h0;
    repeat (3) @(negedge clk);
    chk("reset_data", data_out, 0);
    chk("reset_valid", data_out_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", unload_done, 0);
    rst = 1'b0;
    data_out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_valid", data_out_valid, 0);
    chk("idle_busy", busy, 0);
    for (int i = 0; i < 16; i++) mem_c[i] = i * 32'h0101_0101;
    run(0, -1, -1, 1'b0, NBYTES + 1);
    randomize_mem();
    mem_c[0] = 32'hDEAD_BEEF;
    run(1, -1, -1, 1'b0, 0);
    randomize_mem();
    run(0, -1, -1, 1'b1, NBYTES + 1);
    randomize_mem();
    run(0, 10, -1, 1'b0, NBYTES + 1);
    randomize_mem();
    run(0, -1, 20, 1'b0, 0);
    randomize_mem();
    run(0, -1, -1, 1'b0, NBYTES + 1);
    repeat (3) begin
      randomize_mem();
      run(2, -1, -1, 1'b0, 0);
    end
`ifdef UNLOADER_CHECKSUM_EN
    for (int i = 0; i < 16; i++) mem_c[i] = 32'h0;
    mem_c[0] = 32'h0102_0408;
    run(0, -1, -1, 1'b0, NBYTES + 1);
    chk("cksum_byte", last_rx, 8'h0F);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/result_unloader.md
# result_unloader

Streams the 4x4 result matrix out of the systolic array as a byte stream, the transmit-side counterpart of the byte-wise operand loader. On a start request it snapshots the result matrix, then emits every element row-major, most-significant byte first, over a valid/ready byte interface, and pulses done after the last byte. It sits between the array's result registers and the external byte link.

## Interface
- ROWS, 4, result matrix rows
- COLS, 4, result matrix columns
- ELEM_W, 32, bits per result element; multiple of 8
- clk  input  1  clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- mem_c  input  ELEM_W x [0:ROWS*COLS-1]  result elements, row-major index r*COLS+c
- unload_start  input  1  request to begin unloading; sampled only in IDLE
- data_out  output  8  current byte
- data_out_valid  output  1  data_out holds a valid byte
- data_out_ready  input  1  downstream accepts the byte this cycle
- busy  output  1  high from start acceptance until done
- unload_done  output  1  single-cycle pulse after final byte accepted

## Operation
- Reset values: data_out=0, data_out_valid=0, busy=0, unload_done=0, state IDLE, counters 0.
- States: IDLE, SEND, CKSUM (only with macro), DONE.
- IDLE: on unload_start=1, copy all mem_c into snapshot registers, clear byte counter, set busy, go SEND. unload_start=0: stay.
- SEND: data_out_valid=1; data_out = byte (BPE-1-byte_idx) of snapshot[elem_idx], BPE=ELEM_W/8. Transfer occurs when valid and ready both high. On transfer: advance byte_idx; on byte_idx wrap advance elem_idx. On transfer of final byte (elem ROWS*COLS-1, byte BPE-1): go CKSUM if enabled, else DONE.
- Without transfer, data_out and data_out_valid hold stable (no byte dropped, repeated, or changed).
- DONE: data_out_valid=0, unload_done=1 for exactly this cycle, busy=0 from next cycle, return IDLE.
- unload_start while busy: ignored; no restart, no snapshot update.
- mem_c changes after acceptance: no effect on current stream.
- rst mid-stream: immediately to reset values next cycle; partial stream abandoned, no done pulse.
- Total bytes = ROWS*COLS*BPE (64 at defaults); counters sized with $clog2, no overflow.

## Timing
- Start accepted at edge N (IDLE, unload_start=1); first byte valid from cycle N+1.
- Ready held high: one byte per cycle; 64 bytes occupy cycles N+1..N+64; unload_done high in cycle N+65 (N+66 with checksum).
- busy rises cycle N+1, falls cycle after unload_done.
- Earliest next start accepted in the cycle after unload_done (IDLE).
- data_out_ready is not required to be low when valid is low; ignored then.

## Configuration
- UNLOADER_CHECKSUM_EN defined: after last data byte, state CKSUM presents one extra byte = XOR of all transmitted data bytes, same handshake; done follows its transfer.
- Undefined: no CKSUM state; stream ends with last data byte.

## Structure
- Shared package sa_pkg: ROWS/COLS/ELEM_W defaults, BPE, TOTAL_BYTES constant, state enum typedef for unloader states.
- One natural sub-module: elem_serializer (selects byte from snapshot by elem_idx/byte_idx, combinational mux); counters, FSM, checksum in top.

## Test plan
- Basic: mem_c[i]=32'h0000_0000+i*32'h0101_0101, ready always 1 -> bytes 00,00,00,00,01,01,01,01,... in order, 64 bytes, done at N+65.
- Backpressure: mem_c[0]=32'hDEAD_BEEF, ready toggled 1010 -> DE,AD,BE,EF each held stable while ready=0, no loss or duplication.
- Snapshot: change mem_c to all 32'hFFFF_FFFF one cycle after start -> stream still carries original values.
- Start while busy: pulse unload_start at byte 10 -> ignored, exactly 64 bytes, one done pulse.
- Reset mid-stream: rst at byte 20 -> next cycle valid=0, busy=0, no done; new start sends full stream from byte 0.
- Checksum (macro defined): mem_c[0]=32'h0102_0408, rest 0 -> 65th byte = 8'h0F, done after it.
